// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage valid/ready register chain for signed WIDTH-bit data.
// Each stage advances when it is empty or when the stage ahead of it advances,
// so bubbles collapse under a downstream stall. rst and clr both flush synchronously.

module register_pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             en,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
  output logic [WIDTH-1:0] dout
);
  // Valid follows the upstream slot on enable; data only moves with a valid word
  always_ff @(posedge clk) begin
    if (flush) begin
      vout <= 1'b0;
      dout <= '0;
    end else if (en) begin
      vout <= vin;
      if (vin) dout <= din;
    end
  end
endmodule

module register_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [WIDTH-1:0]    s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [WIDTH-1:0]    m_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);

  // Index 0 is the upstream port; index i+1 is the output of stage i.
  logic [DEPTH:0]            vld_pipe;
  logic [DEPTH:0][WIDTH-1:0] dat_pipe;
  logic [DEPTH:0]            rdy;
  logic                      flush;

  assign flush       = rst | clr;
  assign vld_pipe[0] = s_valid;
  assign dat_pipe[0] = s_data;

  // Ready ripples back from the sink: a stage moves if empty or if the next one moves
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = m_ready;
    for (int i = DEPTH - 1; i >= 0; i--)
      rdy[i] = !vld_pipe[i+1] | rdy[i+1];
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_stage
      register_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .flush (flush),
        .en    (rdy[g]),
        .vin   (vld_pipe[g]),
        .din   (dat_pipe[g]),
        .vout  (vld_pipe[g+1]),
        .dout  (dat_pipe[g+1])
      );
    end
  endgenerate

  assign s_ready = rdy[0] & !rst & !clr;
  assign m_valid = vld_pipe[DEPTH];
  assign m_data  = dat_pipe[DEPTH];

  // Occupancy is a pure popcount of the stage valid flops
  always_comb begin
    count = '0;
    for (int i = 1; i <= DEPTH; i++)
      count = count + CW'(vld_pipe[i]);
  end
endmodule

// File: tb/tb_register_pipe.sv
// Bench for register_pipe: DEPTH=4 and DEPTH=1 instances share one stimulus stream.
// Reference model tracks each in-flight word as (stage position, data) and moves
// words forward by occupancy rules; directed sequences pin literal expectations.
`timescale 1ns/1ps
module tb_register_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1, clr = 1'b0;
  logic s_valid = 1'b0, m_ready = 1'b0;
  logic signed [15:0] s_data = '0;

  logic s_ready4, m_valid4, s_ready1, m_valid1;
  logic signed [15:0] m_data4, m_data1;
  logic [2:0] count4;
  logic [0:0] count1;

  int n_tests = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  register_pipe #(.WIDTH(16), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4), .count(count4));

  register_pipe #(.WIDTH(16), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .count(count1));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Entry 0 is the oldest word; mpos is its stage index (DEPTH-1 = output stage).
  int                 mpos [2][4];
  logic signed [15:0] mdat [2][4];
  int                 mn   [2];
  logic signed [15:0] mlast[2];

  function automatic int dep_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // New position of every word given m_ready; dep means the word left.
  function automatic int next_pos(input int k, input int j, input int ahead, input bit mr);
    int p = mpos[k][j];
    int dep = dep_of(k);
    if (p == dep - 1) return mr ? dep : p;
    return (ahead > p + 1) ? p + 1 : p;
  endfunction

  function automatic bit mdl_sready(input int k, input bit mr);
    int ahead = dep_of(k);
    for (int j = 0; j < mn[k]; j++) ahead = next_pos(k, j, ahead, mr);
    return (mn[k] == 0) || (ahead > 0);
  endfunction

  task automatic mdl_step(input int k, input bit fl, input bit sv, input logic signed [15:0] sd, input bit mr);
    int dep = dep_of(k);
    int ahead = dep;
    int np [4];
    int nn = 0;
    bit acc;
    int                 tp [4];
    logic signed [15:0] td [4];
    if (fl) begin
      mn[k] = 0;
      mlast[k] = '0;
      return;
    end
    acc = sv && mdl_sready(k, mr);
    for (int j = 0; j < mn[k]; j++) begin
      np[j] = next_pos(k, j, ahead, mr);
      ahead = np[j];
    end
    for (int j = 0; j < mn[k]; j++) begin
      if (np[j] < dep) begin
        tp[nn] = np[j];
        td[nn] = mdat[k][j];
        if (np[j] == dep - 1) mlast[k] = mdat[k][j];
        nn++;
      end
    end
    if (acc) begin
      tp[nn] = 0;
      td[nn] = sd;
      if (dep == 1) mlast[k] = sd;
      nn++;
    end
    for (int j = 0; j < nn; j++) begin
      mpos[k][j] = tp[j];
      mdat[k][j] = td[j];
    end
    mn[k] = nn;
  endtask

  // Model advances on the same edge as the DUTs, from the inputs held across it
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) mdl_step(k, rst || clr, s_valid, s_data, m_ready);
  end

  // Every cycle, away from the edge, outputs must equal the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("d4_count",   int'(count4),   mn[0]);
      chk("d4_m_valid", int'(m_valid4), int'(mn[0] > 0 && mpos[0][0] == 3));
      chk("d4_m_data",  int'(m_data4),  int'(mlast[0]));
      chk("d4_s_ready", int'(s_ready4), int'(mdl_sready(0, m_ready) && !rst && !clr));
      chk("d1_count",   int'(count1),   mn[1]);
      chk("d1_m_valid", int'(m_valid1), int'(mn[1] > 0));
      chk("d1_m_data",  int'(m_data1),  int'(mlast[1]));
      chk("d1_s_ready", int'(s_ready1), int'(mdl_sready(1, m_ready) && !rst && !clr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit sv, input int sd, input bit mr);
    s_valid = sv;
    s_data  = 16'(sd);
    m_ready = mr;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  int stream[4] = '{-3, 100, 7, -32768};

  initial begin
    mn[0] = 0; mn[1] = 0; mlast[0] = '0; mlast[1] = '0;
    rst = 1'b1;
    drive(1, 5, 1);
    step;
    cmp_en = 1'b1;
    chk("rst_s_ready", int'(s_ready4), 0);
    step;
    rst = 1'b0;
    drive(0, 0, 1);
    chk("rst_m_valid", int'(m_valid4), 0);
    chk("rst_count",   int'(count4),   0);
    chk("rst_m_data",  int'(m_data4),  0);

    // Streaming: latency DEPTH, one word per cycle
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, (i < 4) ? stream[i] : 0, 1);
      if (i < 4) chk("str_s_ready", int'(s_ready4), 1);
      if (i >= 4) begin
        chk("str_m_valid", int'(m_valid4), 1);
        chk("str_m_data",  int'(m_data4),  stream[i-4]);
      end
      step;
    end
    drive(0, 0, 1);
    repeat (4) step;

    // Fill under stall, then drain while accepting 5 and 6
    for (int i = 0; i < 4; i++) begin
      drive(1, i + 1, 0);
      chk("fill_s_ready", int'(s_ready4), 1);
      step;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 5, 0);
      chk("full_s_ready", int'(s_ready4), 0);
      chk("full_count",   int'(count4),   4);
      chk("full_m_data",  int'(m_data4),  1);
      step;
    end
    for (int i = 0; i < 6; i++) begin
      drive(i < 2, 5 + i, 1);
      if (i < 2) chk("drain_s_ready", int'(s_ready4), 1);
      chk("drain_m_valid", int'(m_valid4), 1);
      chk("drain_m_data",  int'(m_data4),  i + 1);
      step;
    end
    drive(0, 0, 1);
    chk("drain_empty", int'(m_valid4), 0);
    chk("drain_hold",  int'(m_data4),  6);

    // Bubble collapse under stall
    for (int i = 0; i < 8; i++) begin
      drive(i == 0 || i == 3, (i == 0) ? 10 : 20, 0);
      step;
    end
    drive(0, 0, 1);
    chk("bub_count",  int'(count4),  2);
    chk("bub_first",  int'(m_data4), 10);
    step;
    chk("bub_second", int'(m_data4), 20);
    chk("bub_valid",  int'(m_valid4), 1);
    step;
    chk("bub_empty",  int'(m_valid4), 0);

    // Full pass-through
    for (int i = 0; i < 4; i++) begin drive(1, 100 + i, 0); step; end
    for (int i = 0; i < 8; i++) begin
      drive(1, 200 + i, 1);
      chk("pass_s_ready", int'(s_ready4), 1);
      chk("pass_count",   int'(count4),   4);
      chk("pass_m_data",  int'(m_data4),  (i < 4) ? 100 + i : 196 + i);
      step;
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1);
      chk("pass_tail", int'(m_data4), 204 + i);
      step;
    end

    // Flush with three stages occupied
    for (int i = 0; i < 3; i++) begin drive(1, 31 + i, 0); step; end
    chk("fl_count3", int'(count4), 3);
    clr = 1'b1;
    drive(1, 99, 1);
    chk("fl_s_ready", int'(s_ready4), 0);
    step;
    clr = 1'b0;
    drive(0, 0, 1);
    chk("fl_m_valid", int'(m_valid4), 0);
    chk("fl_count",   int'(count4),   0);
    chk("fl_m_data",  int'(m_data4),  0);
    for (int i = 0; i < 6; i++) begin
      step;
      chk("fl_no99", int'(m_valid4), 0);
    end

    // DEPTH=1 instance: one-cycle latency, blocking, back-to-back
    drive(1, 55, 0);
    chk("d1_acc55", int'(s_ready1), 1);
    step;
    drive(1, 56, 0);
    chk("d1_out55",   int'(m_data1),  55);
    chk("d1_v55",     int'(m_valid1), 1);
    chk("d1_blocked", int'(s_ready1), 0);
    step;
    drive(1, 56, 0);
    chk("d1_hold55",  int'(m_data1),  55);
    drive(1, 56, 1);
    chk("d1_pass",    int'(s_ready1), 1);
    step;
    drive(1, 57, 1);
    chk("d1_out56",   int'(m_data1),  56);
    step;
    drive(0, 0, 1);
    chk("d1_out57",   int'(m_data1),  57);
    step;

    // Randomized traffic with occasional flush/reset
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)) - 32768,
            $urandom_range(0, 9) < 6);
      step;
    end
    clr = 1'b0;
    rst = 1'b0;
    drive(0, 0, 1);
    step;
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
